// File: rtl/slinky_bus_if.sv
// Apple II slot-bus front end for the SDRAM controller: Slinky-style 24-bit
// auto-increment pointer plus data port with a one-byte read-ahead buffer.
module slinky_bus_if #(
  parameter int unsigned ADDR_BITS = 24,
  parameter int unsigned DEC_DLY   = 1,
  parameter int unsigned HOLD_CYC  = 3,
  parameter logic [7:0]  ID_BYTE   = 8'hA5
) (
  input  logic        c8m,
  input  logic        nreset,
  input  logic        phi2,
  input  logic        ndevsel,
  input  logic        rnw,
  input  logic [3:0]  ba,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        doe,
  output logic        rdcmd,
  output logic        wrcmd,
  output logic [23:0] a,
  output logic [7:0]  wrd,
  input  logic [7:0]  rdd
);

  localparam logic [23:0] PtrMask =
    (ADDR_BITS >= 24) ? 24'hFFFFFF : 24'((32'd1 << ADDR_BITS) - 32'd1);
  localparam logic [7:0] DecLast  = (DEC_DLY  > 0) ? 8'(DEC_DLY - 1)  : 8'd0;
  localparam logic [7:0] HoldLast = (HOLD_CYC > 0) ? 8'(HOLD_CYC - 1) : 8'd0;

  typedef enum logic [1:0] {StIdle, StWait, StArmed, StHold} state_e;
  typedef enum logic [2:0] {AcNone, AcDataRd, AcDataWr, AcPrefetch, AcAddrWr} access_e;

  logic        phi2_s1_q, phi2_s2_q, phi2_s3_q;
  logic        rise, fall;
  state_e      state_q, state_d;
  access_e     kind_q, kind_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  sel_byte_q, sel_byte_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [23:0] ptr_q, ptr_d;
  logic [7:0]  dbuf_q, dbuf_d;
  logic        pf_q, pf_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        rdcmd_q, rdcmd_d;
  logic        wrcmd_q, wrcmd_d;
  logic [23:0] a_q, a_d;
  logic [7:0]  wrd_q, wrd_d;
  logic [23:0] ptr_inc;
  logic [23:0] ptr_wr;

  assign rise = phi2_s2_q & ~phi2_s3_q;
  assign fall = ~phi2_s2_q & phi2_s3_q;

  assign ptr_inc = (ptr_q + 24'd1) & PtrMask;

  always_comb begin
    ptr_wr = ptr_q;
    case (sel_byte_q)
      2'd0:    ptr_wr[7:0]   = wbyte_q;
      2'd1:    ptr_wr[15:8]  = wbyte_q;
      default: ptr_wr[23:16] = wbyte_q;
    endcase
    ptr_wr = ptr_wr & PtrMask;
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = cnt_q;
    sel_byte_d = sel_byte_q;
    wbyte_d    = wbyte_q;
    ptr_d      = ptr_q;
    dbuf_d     = dbuf_q;
    pf_d       = pf_q;
    dout_d     = dout_q;
    doe_d      = doe_q;
    rdcmd_d    = rdcmd_q;
    wrcmd_d    = wrcmd_q;
    a_d        = a_q;
    wrd_d      = wrd_q;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StWait;
          cnt_d   = 8'd0;
        end
      end

      StWait: begin
        if (fall) begin
          // Phase lost before decode; drop this PHI2 cycle.
          state_d = StIdle;
        end else if (cnt_q == DecLast) begin
          state_d    = StArmed;
          kind_d     = AcNone;
          sel_byte_d = ba[1:0];
          if (!ndevsel) begin
            if (ba == 4'h3) begin
              if (rnw) begin
                dout_d  = dbuf_q;
                doe_d   = 1'b1;
                rdcmd_d = 1'b1;
                a_d     = ptr_inc;
                kind_d  = AcDataRd;
              end else begin
                wrcmd_d = 1'b1;
                a_d     = ptr_q;
                wrd_d   = din;
                kind_d  = AcDataWr;
              end
            end else if (rnw) begin
              doe_d = 1'b1;
              case (ba)
                4'h0:    dout_d = ptr_q[7:0];
                4'h1:    dout_d = ptr_q[15:8];
                4'h2:    dout_d = ptr_q[23:16];
                4'hF:    dout_d = ID_BYTE;
                default: dout_d = 8'hFF;
              endcase
            end else if (ba < 4'h3) begin
              kind_d = AcAddrWr;
            end
          end else if (pf_q) begin
            // Only bus cycles not addressed to us refill the read-ahead buffer.
            rdcmd_d = 1'b1;
            a_d     = ptr_q;
            kind_d  = AcPrefetch;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StArmed: begin
        if (kind_q == AcDataWr) begin
          wrd_d = din;
        end
        if (fall) begin
          state_d = StHold;
          cnt_d   = 8'd0;
          doe_d   = 1'b0;
          if (kind_q == AcAddrWr) begin
            wbyte_d = din;
          end
        end
      end

      StHold: begin
        // A new rise here is deliberately ignored.
        if (cnt_q == HoldLast) begin
          state_d = StIdle;
          rdcmd_d = 1'b0;
          wrcmd_d = 1'b0;
          a_d     = 24'd0;
          case (kind_q)
            AcDataRd: begin
              ptr_d  = ptr_inc;
              dbuf_d = rdd;
              pf_d   = 1'b0;
            end
            AcDataWr: begin
              ptr_d = ptr_inc;
              pf_d  = 1'b1;
            end
            AcPrefetch: begin
              dbuf_d = rdd;
              pf_d   = 1'b0;
            end
            AcAddrWr: begin
              ptr_d = ptr_wr;
              pf_d  = 1'b1;
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge c8m) begin
    if (!nreset) begin
      phi2_s1_q  <= 1'b0;
      phi2_s2_q  <= 1'b0;
      phi2_s3_q  <= 1'b0;
      state_q    <= StIdle;
      kind_q     <= AcNone;
      cnt_q      <= 8'd0;
      sel_byte_q <= 2'd0;
      wbyte_q    <= 8'd0;
      ptr_q      <= 24'd0;
      dbuf_q     <= 8'hFF;
      pf_q       <= 1'b1;
      dout_q     <= 8'hFF;
      doe_q      <= 1'b0;
      rdcmd_q    <= 1'b0;
      wrcmd_q    <= 1'b0;
      a_q        <= 24'd0;
      wrd_q      <= 8'd0;
    end else begin
      phi2_s1_q  <= phi2;
      phi2_s2_q  <= phi2_s1_q;
      phi2_s3_q  <= phi2_s2_q;
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      sel_byte_q <= sel_byte_d;
      wbyte_q    <= wbyte_d;
      ptr_q      <= ptr_d;
      dbuf_q     <= dbuf_d;
      pf_q       <= pf_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
      rdcmd_q    <= rdcmd_d;
      wrcmd_q    <= wrcmd_d;
      a_q        <= a_d & PtrMask;
      wrd_q      <= wrd_d;
    end
  end

  assign dout  = dout_q;
  assign doe   = doe_q;
  assign rdcmd = rdcmd_q;
  assign wrcmd = wrcmd_q;
  assign a     = a_q;
  assign wrd   = wrd_q;

endmodule

// File: tb/tb_slinky_bus_if.sv
// Directed bench for slinky_bus_if: drives PHI2 bus cycles and checks the SDRAM
// command stream and CPU read data against hand-derived values.
module tb_slinky_bus_if;

  logic        c8m = 1'b0;
  logic        nreset;
  logic        phi2;
  logic        ndevsel;
  logic        rnw;
  logic [3:0]  ba;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        doe;
  logic        rdcmd;
  logic        wrcmd;
  logic [23:0] a;
  logic [7:0]  wrd;
  logic [7:0]  rdd;

  int checks = 0;
  int errors = 0;

  // Per-cycle observations filled by bus_cycle.
  logic        got_rd, got_wr, doe_after;
  logic [7:0]  cyc_dout;

  // Monitor state, written only by the monitor process.
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  int          both_cnt = 0;
  logic [23:0] rd_a = '0;
  logic [23:0] wr_a = '0;
  logic [7:0]  wr_d = '0;

  always #5 c8m = ~c8m;

  function automatic logic [7:0] mem(input logic [23:0] ad);
    return ad[7:0] ^ ad[15:8] ^ ad[23:16] ^ 8'h3C;
  endfunction

  assign rdd = mem(a);

  slinky_bus_if dut (
    .c8m    (c8m),
    .nreset (nreset),
    .phi2   (phi2),
    .ndevsel(ndevsel),
    .rnw    (rnw),
    .ba     (ba),
    .din    (din),
    .dout   (dout),
    .doe    (doe),
    .rdcmd  (rdcmd),
    .wrcmd  (wrcmd),
    .a      (a),
    .wrd    (wrd),
    .rdd    (rdd)
  );

  always @(negedge c8m) begin
    if (rdcmd) begin
      rd_cyc = rd_cyc + 1;
      rd_a   = a;
    end
    if (wrcmd) begin
      wr_cyc = wr_cyc + 1;
      wr_a   = a;
      wr_d   = wrd;
    end
    if (rdcmd && wrcmd) both_cnt = both_cnt + 1;
  end

  // One PHI2 cycle: 6 C8M high, 8 C8M low.
  task automatic bus_cycle(input logic sel, input logic rd, input logic [3:0] off,
                           input logic [7:0] data);
    int r0, w0;
    @(negedge c8m);
    ndevsel = ~sel;
    rnw     = rd;
    ba      = off;
    din     = data;
    phi2    = 1'b1;
    r0      = rd_cyc;
    w0      = wr_cyc;
    repeat (6) @(negedge c8m);
    cyc_dout = dout;
    phi2     = 1'b0;
    repeat (8) @(negedge c8m);
    ndevsel   = 1'b1;
    rnw       = 1'b1;
    got_rd    = (rd_cyc != r0);
    got_wr    = (wr_cyc != w0);
    doe_after = doe;
  endtask

  task automatic set_ptr(input logic [23:0] p);
    bus_cycle(1'b1, 1'b0, 4'h0, p[7:0]);
    bus_cycle(1'b1, 1'b0, 4'h1, p[15:8]);
    bus_cycle(1'b1, 1'b0, 4'h2, p[23:16]);
  endtask

  task automatic test_reset;
    nreset = 1'b0; phi2 = 1'b0; ndevsel = 1'b1; rnw = 1'b1; ba = 4'h0; din = 8'h00;
    repeat (3) @(negedge c8m);
    checks++; if (rdcmd !== 1'b0) begin errors++; $display("FAIL reset_rdcmd got %b want 0", rdcmd); end
    checks++; if (wrcmd !== 1'b0) begin errors++; $display("FAIL reset_wrcmd got %b want 0", wrcmd); end
    checks++; if (doe !== 1'b0) begin errors++; $display("FAIL reset_doe got %b want 0", doe); end
    checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL reset_dout got %h want ff", dout); end
    checks++; if (a !== 24'h0) begin errors++; $display("FAIL reset_a got %h want 0", a); end
    checks++; if (wrd !== 8'h00) begin errors++; $display("FAIL reset_wrd got %h want 0", wrd); end
    nreset = 1'b1;
    repeat (2) @(negedge c8m);
  endtask

  task automatic test_prefetch;
    bus_cycle(1'b0, 1'b1, 4'h0, 8'h00);
    checks++; if (got_rd !== 1'b1) begin errors++; $display("FAIL pf_rdcmd got %b want 1", got_rd); end
    checks++; if (rd_a !== 24'h0) begin errors++; $display("FAIL pf_addr got %h want 0", rd_a); end
    checks++; if (got_wr !== 1'b0) begin errors++; $display("FAIL pf_nowr got %b want 0", got_wr); end
    bus_cycle(1'b1, 1'b1, 4'h3, 8'h00);
    checks++; if (cyc_dout !== mem(24'h0)) begin errors++; $display("FAIL pf_data got %h want %h", cyc_dout, mem(24'h0)); end
    checks++; if (rd_a !== 24'h1) begin errors++; $display("FAIL rd_ahead_addr got %h want 1", rd_a); end
    checks++; if (doe_after !== 1'b0) begin errors++; $display("FAIL doe_after_fall got %b want 0", doe_after); end
  endtask

  task automatic test_addr_write;
    int r0, w0;
    r0 = rd_cyc; w0 = wr_cyc;
    set_ptr(24'h563412);
    checks++; if ((rd_cyc != r0) || (wr_cyc != w0)) begin errors++; $display("FAIL addr_wr_nocmd got rd=%0d wr=%0d want 0", rd_cyc - r0, wr_cyc - w0); end
    bus_cycle(1'b0, 1'b1, 4'h0, 8'h00);
    checks++; if (rd_a !== 24'h563412) begin errors++; $display("FAIL addr_pf got %h want 563412", rd_a); end
    bus_cycle(1'b1, 1'b1, 4'h3, 8'h00);
    checks++; if (cyc_dout !== mem(24'h563412)) begin errors++; $display("FAIL addr_data got %h want %h", cyc_dout, mem(24'h563412)); end
    checks++; if (rd_a !== 24'h563413) begin errors++; $display("FAIL addr_ahead got %h want 563413", rd_a); end
    bus_cycle(1'b1, 1'b1, 4'h0, 8'h00);
    checks++; if (cyc_dout !== 8'h13) begin errors++; $display("FAIL ptr_b0 got %h want 13", cyc_dout); end
    bus_cycle(1'b1, 1'b1, 4'h1, 8'h00);
    checks++; if (cyc_dout !== 8'h34) begin errors++; $display("FAIL ptr_b1 got %h want 34", cyc_dout); end
    bus_cycle(1'b1, 1'b1, 4'h2, 8'h00);
    checks++; if (cyc_dout !== 8'h56) begin errors++; $display("FAIL ptr_b2 got %h want 56", cyc_dout); end
  endtask

  task automatic test_data_write;
    set_ptr(24'h000000);
    for (int i = 0; i < 3; i++) begin
      bus_cycle(1'b1, 1'b0, 4'h3, 8'h9C);
      checks++; if (got_wr !== 1'b1) begin errors++; $display("FAIL wr%0d_cmd got %b want 1", i, got_wr); end
      checks++; if (wr_a !== 24'(i)) begin errors++; $display("FAIL wr%0d_addr got %h want %h", i, wr_a, 24'(i)); end
      checks++; if (wr_d !== 8'h9C) begin errors++; $display("FAIL wr%0d_data got %h want 9c", i, wr_d); end
      checks++; if (got_rd !== 1'b0) begin errors++; $display("FAIL wr%0d_nord got %b want 0", i, got_rd); end
    end
    bus_cycle(1'b1, 1'b1, 4'h0, 8'h00);
    checks++; if (cyc_dout !== 8'h03) begin errors++; $display("FAIL wr_ptr got %h want 03", cyc_dout); end
    bus_cycle(1'b0, 1'b1, 4'h0, 8'h00);
    checks++; if ((got_rd !== 1'b1) || (rd_a !== 24'h3)) begin errors++; $display("FAIL wr_pf got rd=%b a=%h want 1 000003", got_rd, rd_a); end
  endtask

  task automatic test_wrap;
    set_ptr(24'hFFFFFF);
    bus_cycle(1'b0, 1'b1, 4'h0, 8'h00);
    checks++; if (rd_a !== 24'hFFFFFF) begin errors++; $display("FAIL wrap_pf got %h want ffffff", rd_a); end
    bus_cycle(1'b1, 1'b1, 4'h3, 8'h00);
    checks++; if (cyc_dout !== mem(24'hFFFFFF)) begin errors++; $display("FAIL wrap_data got %h want %h", cyc_dout, mem(24'hFFFFFF)); end
    checks++; if (rd_a !== 24'h0) begin errors++; $display("FAIL wrap_ahead got %h want 0", rd_a); end
    for (int i = 0; i < 3; i++) begin
      bus_cycle(1'b1, 1'b1, 4'(i), 8'h00);
      checks++; if (cyc_dout !== 8'h00) begin errors++; $display("FAIL wrap_ptr%0d got %h want 00", i, cyc_dout); end
    end
  endtask

  task automatic test_regs;
    bus_cycle(1'b1, 1'b1, 4'hF, 8'h00);
    checks++; if (cyc_dout !== 8'hA5) begin errors++; $display("FAIL id_byte got %h want a5", cyc_dout); end
    bus_cycle(1'b1, 1'b1, 4'h7, 8'h00);
    checks++; if (cyc_dout !== 8'hFF) begin errors++; $display("FAIL unused_rd got %h want ff", cyc_dout); end
    checks++; if (got_rd !== 1'b0) begin errors++; $display("FAIL unused_rd_nocmd got %b want 0", got_rd); end
    bus_cycle(1'b1, 1'b0, 4'h7, 8'hAA);
    checks++; if ((got_rd !== 1'b0) || (got_wr !== 1'b0)) begin errors++; $display("FAIL unused_wr_nocmd got rd=%b wr=%b want 0 0", got_rd, got_wr); end
  endtask

  task automatic test_stale;
    bus_cycle(1'b1, 1'b0, 4'h0, 8'h05);
    bus_cycle(1'b1, 1'b1, 4'h3, 8'h00);
    checks++; if (cyc_dout !== mem(24'h0)) begin errors++; $display("FAIL stale_data got %h want %h", cyc_dout, mem(24'h0)); end
    checks++; if (rd_a !== 24'h6) begin errors++; $display("FAIL stale_ahead got %h want 000006", rd_a); end
    bus_cycle(1'b1, 1'b1, 4'h3, 8'h00);
    checks++; if (cyc_dout !== mem(24'h6)) begin errors++; $display("FAIL after_stale got %h want %h", cyc_dout, mem(24'h6)); end
    checks++; if (rd_a !== 24'h7) begin errors++; $display("FAIL after_stale_ahead got %h want 000007", rd_a); end
  endtask

  task automatic test_reset_hold;
    @(negedge c8m);
    ndevsel = 1'b0; rnw = 1'b0; ba = 4'h3; din = 8'h77; phi2 = 1'b1;
    repeat (6) @(negedge c8m);
    phi2 = 1'b0;
    repeat (4) @(negedge c8m);
    checks++; if ((wrcmd !== 1'b1) || (a !== 24'h7)) begin errors++; $display("FAIL hold_wr got wrcmd=%b a=%h want 1 000007", wrcmd, a); end
    nreset = 1'b0;
    @(negedge c8m);
    checks++; if (wrcmd !== 1'b0) begin errors++; $display("FAIL rst_hold_wrcmd got %b want 0", wrcmd); end
    checks++; if (a !== 24'h0) begin errors++; $display("FAIL rst_hold_a got %h want 0", a); end
    nreset = 1'b1; ndevsel = 1'b1; rnw = 1'b1;
    repeat (4) @(negedge c8m);
    bus_cycle(1'b1, 1'b1, 4'h0, 8'h00);
    checks++; if (cyc_dout !== 8'h00) begin errors++; $display("FAIL rst_ptr got %h want 00", cyc_dout); end
    bus_cycle(1'b1, 1'b1, 4'h3, 8'h00);
    checks++; if (cyc_dout !== 8'hFF) begin errors++; $display("FAIL rst_dbuf got %h want ff", cyc_dout); end
    checks++; if (rd_a !== 24'h1) begin errors++; $display("FAIL rst_ahead got %h want 000001", rd_a); end
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_addr_write();
    test_data_write();
    test_wrap();
    test_regs();
    test_stale();
    test_reset_hold();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL cmd_exclusive got %0d overlaps want 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
